// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-side and D-side requesters.
// The winner's command is latched at grant so the downstream request stays stable
// until memory responds.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    // instruction-side requester
    input  logic                i_read,
    input  logic                i_write,
    input  logic [DATA_W/8-1:0] i_byte_enable,
    input  logic [ADDR_W-1:0]   i_address,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic                i_resp,
    output logic [DATA_W-1:0]   i_rdata,
    // data-side requester
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W/8-1:0] d_byte_enable,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_resp,
    output logic [DATA_W-1:0]   d_rdata,
    // downstream memory port
    output logic                mem_read,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byte_enable,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_resp,
    input  logic [DATA_W-1:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_last_d;   // 1 = D side won the most recent grant
    logic                  r_op_wr;    // latched op: 1 = write, 0 = read
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_be;

    logic                  w_req_i;
    logic                  w_req_d;
    logic                  w_grant_i;
    logic                  w_grant_d;

    assign w_req_i = i_read | i_write;
    assign w_req_d = d_read | d_write;

    // Next-state and grant selection; ties go to the side not granted last.
    always_comb begin
        w_next    = r_state;
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req_i && w_req_d) begin
                    w_grant_i = r_last_d;
                    w_grant_d = ~r_last_d;
                end else begin
                    w_grant_i = w_req_i;
                    w_grant_d = w_req_d;
                end
                if (w_grant_i)      w_next = SERVE_I;
                else if (w_grant_d) w_next = SERVE_D;
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // State, fairness flag and command registers; the command is captured only on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_last_d <= 1'b0;
            r_op_wr  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant_i) begin
                r_last_d <= 1'b0;
                r_op_wr  <= i_write;
                r_addr   <= i_address;
                r_wdata  <= i_wdata;
                r_be     <= i_byte_enable;
            end else if (w_grant_d) begin
                r_last_d <= 1'b1;
                r_op_wr  <= d_write;
                r_addr   <= d_address;
                r_wdata  <= d_wdata;
                r_be     <= d_byte_enable;
            end
        end
    end

    // Downstream strobes come only from registered state, never from requester inputs.
    assign mem_read        = (r_state != IDLE) & ~r_op_wr;
    assign mem_write       = (r_state != IDLE) &  r_op_wr;
    assign mem_address     = r_addr;
    assign mem_wdata       = r_wdata;
    assign mem_byte_enable = r_be;

    // Completion is routed only to the side being served; read data is shared.
    assign i_resp  = (r_state == SERVE_I) & mem_resp;
    assign d_resp  = (r_state == SERVE_D) & mem_resp;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected completions, a monitor
// pops and checks them whenever either side's resp pulses.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_read, i_write, d_read, d_write;
    logic [DW/8-1:0] i_byte_enable, d_byte_enable, mem_byte_enable;
    logic [AW-1:0]   i_address, d_address, mem_address;
    logic [DW-1:0]   i_wdata, d_wdata, mem_wdata;
    logic            i_resp, d_resp;
    logic [DW-1:0]   i_rdata, d_rdata, mem_rdata;
    logic            mem_read, mem_write, mem_resp;

    // memory model controls
    logic            model_resp;
    logic            force_resp;
    bit              resp_en;
    int              lat;
    int              cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          side_d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] rdata;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_write(i_write), .i_byte_enable(i_byte_enable),
        .i_address(i_address), .i_wdata(i_wdata), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
        .d_address(d_address), .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    // Memory returns address ^ 0x73 as read data (0x60 -> 0x13).
    assign mem_rdata = mem_address ^ 32'h73;
    assign mem_resp  = model_resp | force_resp;

    // Memory model: responds after lat extra cycles of a held request.
    always @(posedge clk) begin
        #1;
        if (rst || !resp_en || !(mem_read || mem_write)) begin
            model_resp = 1'b0;
            cnt = 0;
        end else if (cnt == lat) begin
            model_resp = 1'b1;
            cnt = 0;
        end else begin
            model_resp = 1'b0;
            cnt++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completion must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (i_resp || d_resp)) begin
            if (i_resp && d_resp) begin
                checks++; errors++;
                $display("FAIL both_resp: i_resp=1 d_resp=1 expected one");
            end else if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_resp: i_resp=%0b d_resp=%0b expected none", i_resp, d_resp);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_side", {63'd0, d_resp}, {63'd0, e.side_d});
                chk("resp_op_wr", {63'd0, mem_write}, {63'd0, e.wr});
                chk("resp_addr", {32'd0, mem_address}, {32'd0, e.addr});
                if (!e.wr)
                    chk("resp_rdata", {32'd0, (e.side_d ? d_rdata : i_rdata)}, {32'd0, e.rdata});
            end
        end
    end

    task automatic push(input bit side_d, input bit wr, input logic [31:0] addr, input logic [31:0] rdata);
        exp_t e;
        e.side_d = side_d; e.wr = wr; e.addr = addr; e.rdata = rdata;
        q.push_back(e);
    endtask

    // Wait (bounded) at negedges until the chosen side responds.
    task automatic wait_resp(input bit side_d);
        int n = 0;
        while (!(side_d ? d_resp : i_resp) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL wait_resp_timeout: side_d=%0b no resp in 50 cycles", side_d);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_read = 0; i_write = 0; i_byte_enable = '0; i_address = '0; i_wdata = '0;
        d_read = 0; d_write = 0; d_byte_enable = '0; d_address = '0; d_wdata = '0;
        model_resp = 0; force_resp = 0; resp_en = 1; lat = 2; cnt = 0;
        repeat (2) @(negedge clk);

        // reset values
        chk("rst_mem_rd_wr", {62'd0, mem_read, mem_write}, 64'd0);
        chk("rst_cmd", {mem_address, mem_wdata}, 64'd0);
        chk("rst_be_resp", {58'd0, mem_byte_enable, i_resp, d_resp}, 64'd0);
        rst = 1'b0;

        // single I read, memory answers on the third SERVE cycle
        i_read = 1; i_address = 32'h60; i_byte_enable = 4'hF;
        push(0, 0, 32'h60, 32'h13);
        @(negedge clk);
        chk("t1_grant_rd", {63'd0, mem_read}, 64'd1);
        chk("t1_grant_addr", {32'd0, mem_address}, 64'h60);
        wait_resp(0);
        chk("t1_d_resp_low", {63'd0, d_resp}, 64'd0);
        i_read = 0;
        @(negedge clk);
        chk("t1_idle_rd", {63'd0, mem_read}, 64'd0);

        // contention right after reset: D wins, then I after one bubble
        rst = 1; @(negedge clk); rst = 0;
        lat = 1;
        i_read = 1; i_address = 32'h200;
        d_write = 1; d_address = 32'h100; d_wdata = 32'hDEADBEEF; d_byte_enable = 4'hF;
        push(1, 1, 32'h100, 32'h0);
        push(0, 0, 32'h200, 32'h273);
        @(negedge clk);
        chk("t2_d_first", {31'd0, mem_write, mem_address}, {31'd0, 1'b1, 32'h100});
        chk("t2_wdata_be", {28'd0, mem_byte_enable, mem_wdata}, {28'd0, 4'hF, 32'hDEADBEEF});
        wait_resp(1);
        d_write = 0;
        @(negedge clk);
        chk("t2_bubble", {62'd0, mem_read, mem_write}, 64'd0);
        @(negedge clk);
        chk("t2_i_next", {31'd0, mem_read, mem_address}, {31'd0, 1'b1, 32'h200});
        wait_resp(0);
        i_read = 0;
        @(negedge clk);

        // alternation: both keep requesting; last grant was I, so D, I, D, I ...
        d_write = 1; d_address = 32'h300;
        i_read = 1; i_address = 32'h400;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) push(1, 1, 32'h300, 32'h0);
            else            push(0, 0, 32'h400, 32'h473);
        end
        for (int k = 0; k < 8; k++) begin
            int n = 0;
            bit side;
            while (!(i_resp || d_resp) && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) begin
                checks++; errors++;
                $display("FAIL alt_timeout: transaction %0d never completed", k);
                break;
            end
            side = d_resp;
            if (k == 7) begin
                d_write = 0; i_read = 0;
                @(negedge clk);
            end else begin
                if (side) d_write = 0; else i_read = 0;
                @(negedge clk);
                if (side) d_write = 1; else i_read = 1;
            end
        end
        @(negedge clk);

        // command stability while requester changes inputs
        lat = 3;
        i_read = 1; i_address = 32'h60;
        push(0, 0, 32'h60, 32'h13);
        @(negedge clk);
        chk("t4_grant", {31'd0, mem_read, mem_address}, {31'd0, 1'b1, 32'h60});
        i_address = 32'h64; i_read = 0;
        @(negedge clk);
        chk("t4_hold", {31'd0, mem_read, mem_address}, {31'd0, 1'b1, 32'h60});
        wait_resp(0);
        chk("t4_at_resp", {31'd0, mem_read, mem_address}, {31'd0, 1'b1, 32'h60});
        @(negedge clk);

        // reset mid-transaction, then a late mem_resp must be ignored
        resp_en = 0;
        d_write = 1; d_address = 32'h500; d_wdata = 32'h55; d_byte_enable = 4'h1;
        @(negedge clk);
        chk("t5_serve_d", {63'd0, mem_write}, 64'd1);
        rst = 1;
        @(negedge clk);
        chk("t5_after_rst", {30'd0, mem_read, mem_write, mem_address}, 64'd0);
        rst = 0; d_write = 0; force_resp = 1;
        @(negedge clk);
        chk("t5_late_resp", {62'd0, i_resp, d_resp}, 64'd0);
        @(negedge clk);
        chk("t5_late_resp2", {62'd0, i_resp, d_resp}, 64'd0);
        force_resp = 0; resp_en = 1;
        @(negedge clk);

        // read+write together with memory resp tied high: write wins, one SERVE cycle
        force_resp = 1;
        d_read = 1; d_write = 1; d_address = 32'h600; d_wdata = 32'h12345678; d_byte_enable = 4'h3;
        push(1, 1, 32'h600, 32'h0);
        @(negedge clk);
        chk("t6_write_wins", {62'd0, mem_read, mem_write}, 64'd1);
        chk("t6_zero_wait", {63'd0, d_resp}, 64'd1);
        d_read = 0; d_write = 0;
        @(negedge clk);
        chk("t6_idle", {61'd0, mem_write, d_resp, i_resp}, 64'd0);
        force_resp = 0;
        @(negedge clk);

        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
